// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the execute-stage ALU arbiter.
package alu_arb_pkg;
    localparam int XLEN_DEF   = 64;
    localparam int INST_W_DEF = 32;
    localparam int AW_DEF     = 5;

    typedef logic arb_id_t;
    localparam arb_id_t ARB_REQ0 = 1'b0;
    localparam arb_id_t ARB_REQ1 = 1'b1;
endpackage

// File: rtl/alu_arb_if.sv
// Request, ALU-side and response signals of the ALU arbiter.
interface alu_arb_if #(
    parameter int XLEN   = 64,
    parameter int INST_W = 32,
    parameter int AW     = 5
);
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [INST_W-1:0] req0_inst, req1_inst;
    logic [XLEN-1:0]   req0_pc, req0_op1, req0_op2, req1_pc, req1_op1, req1_op2;
    logic              req0_we, req1_we;
    logic [AW-1:0]     req0_waddr, req1_waddr;

    logic [INST_W-1:0] alu_inst;
    logic [XLEN-1:0]   alu_inst_addr, alu_op1, alu_op2, alu_wdata;
    logic              alu_we, alu_wreg;
    logic [AW-1:0]     alu_waddr, alu_wd;

    logic              rsp_valid, rsp_ready, rsp_id, rsp_we;
    logic [AW-1:0]     rsp_waddr;
    logic [XLEN-1:0]   rsp_wdata;

    modport slave (
        input  req0_valid, req0_inst, req0_pc, req0_op1, req0_op2, req0_we, req0_waddr,
        input  req1_valid, req1_inst, req1_pc, req1_op1, req1_op2, req1_we, req1_waddr,
        output req0_ready, req1_ready,
        output alu_inst, alu_inst_addr, alu_op1, alu_op2, alu_we, alu_waddr,
        input  alu_wd, alu_wreg, alu_wdata,
        output rsp_valid, rsp_id, rsp_waddr, rsp_we, rsp_wdata,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_inst, req0_pc, req0_op1, req0_op2, req0_we, req0_waddr,
        output req1_valid, req1_inst, req1_pc, req1_op1, req1_op2, req1_we, req1_waddr,
        input  req0_ready, req1_ready,
        input  alu_inst, alu_inst_addr, alu_op1, alu_op2, alu_we, alu_waddr,
        output alu_wd, alu_wreg, alu_wdata,
        input  rsp_valid, rsp_id, rsp_waddr, rsp_we, rsp_wdata,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arb_rr_arb2.sv
// Two-way round-robin grant; the pointer is owned by the caller.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic       v0_i,
    input  logic       v1_i,
    input  arb_id_t    ptr_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output arb_id_t    gid_o
);
    always_comb begin
        gid_o = (v0_i && v1_i) ? ptr_i : (v1_i ? ARB_REQ1 : ARB_REQ0);
        gnt_o = '0;
        if (en_i && (v0_i || v1_i))
            gnt_o[gid_o] = 1'b1;
    end
endmodule

// File: rtl/alu_arb.sv
// Shares the execute ALU between two issuers: S0 holds granted operands,
// S1 buffers the ALU result behind valid/ready.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int AW     = AW_DEF
) (
    input logic      clk,
    input logic      rst,
    alu_arb_if.slave bus
);
    logic [INST_W-1:0] inst_q;
    logic [XLEN-1:0]   pc_q, op1_q, op2_q;
    logic              we_q;
    logic [AW-1:0]     waddr_q;
    arb_id_t           id_q;
    logic              s0_valid_q, s0_valid_d;

    logic [XLEN-1:0]   s1_wdata_q;
    logic [AW-1:0]     s1_waddr_q;
    logic              s1_we_q;
    arb_id_t           s1_id_q;
    logic              s1_valid_q, s1_valid_d;

    arb_id_t           rr_ptr_q;
    logic              adv1, s0_free, acc;
    logic [1:0]        gnt;
    arb_id_t           gid;

    assign adv1    = s0_valid_q && (!s1_valid_q || bus.rsp_ready);
    assign s0_free = !s0_valid_q || adv1;
    assign acc     = |gnt;

    // Ready is withheld during reset so nothing is accepted into a clearing pipe.
    rr_arb2 u_arb (
        .v0_i  (bus.req0_valid),
        .v1_i  (bus.req1_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (s0_free && !rst),
        .gnt_o (gnt),
        .gid_o (gid)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    always_comb begin
        s0_valid_d = s0_valid_q;
        s1_valid_d = s1_valid_q;
        if (acc)       s0_valid_d = 1'b1;
        else if (adv1) s0_valid_d = 1'b0;
        if (adv1)                s1_valid_d = 1'b1;
        else if (bus.rsp_ready)  s1_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q     <= '0;
            pc_q       <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            id_q       <= ARB_REQ0;
            s0_valid_q <= 1'b0;
            s1_wdata_q <= '0;
            s1_waddr_q <= '0;
            s1_we_q    <= 1'b0;
            s1_id_q    <= ARB_REQ0;
            s1_valid_q <= 1'b0;
            rr_ptr_q   <= ARB_REQ0;
        end else begin
            if (acc) begin
                inst_q   <= gid ? bus.req1_inst  : bus.req0_inst;
                pc_q     <= gid ? bus.req1_pc    : bus.req0_pc;
                op1_q    <= gid ? bus.req1_op1   : bus.req0_op1;
                op2_q    <= gid ? bus.req1_op2   : bus.req0_op2;
                we_q     <= gid ? bus.req1_we    : bus.req0_we;
                waddr_q  <= gid ? bus.req1_waddr : bus.req0_waddr;
                id_q     <= gid;
                rr_ptr_q <= ~gid;
            end
            if (adv1) begin
                s1_wdata_q <= bus.alu_wdata;
                s1_waddr_q <= bus.alu_wd;
                s1_we_q    <= bus.alu_wreg;
                s1_id_q    <= id_q;
            end
            s0_valid_q <= s0_valid_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    assign bus.alu_inst      = inst_q;
    assign bus.alu_inst_addr = pc_q;
    assign bus.alu_op1       = op1_q;
    assign bus.alu_op2       = op2_q;
    assign bus.alu_we        = we_q;
    assign bus.alu_waddr     = waddr_q;

    assign bus.rsp_valid = s1_valid_q;
    assign bus.rsp_id    = s1_id_q;
    assign bus.rsp_waddr = s1_waddr_q;
    assign bus.rsp_we    = s1_we_q;
    assign bus.rsp_wdata = s1_wdata_q;
endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: two-slot pipeline model with round-robin fairness, plus directed literals.
module tb_alu_arb;
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc, op1, op2;
        logic        we;
        logic [4:0]  waddr;
        logic        id;
    } item_t;

    logic clk = 1'b0, rst = 1'b1;
    alu_arb_if bus ();

    alu_arb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference ALU beside the block: ADDI-style adds, everything else returns zero.
    assign bus.alu_wdata = (bus.alu_inst[6:0] == 7'b0010011) ? bus.alu_op1 + bus.alu_op2 : 64'd0;
    assign bus.alu_wd    = bus.alu_waddr;
    assign bus.alu_wreg  = bus.alu_we;

    int nchk = 0, nerr = 0;
    logic rst_v = 1'b1, rdy_v = 1'b1;
    item_t q0[$], q1[$];
    bit acc_log[$];
    bit rsp_id_log[$];
    logic [63:0] rsp_wd_log[$];

    item_t m_mid;
    bit m_mid_v, m_out_v, m_ptr;
    logic [63:0] m_out_wd;
    logic [4:0]  m_out_wa;
    logic        m_out_we, m_out_id;

    function automatic logic [63:0] ref_alu(item_t it);
        return (it.inst[6:0] == 7'b0010011) ? it.op1 + it.op2 : 64'd0;
    endfunction

    function automatic item_t mk(logic [31:0] inst, logic [63:0] a, logic [63:0] b,
                                 logic [4:0] wa, logic we);
        item_t it;
        it = '0;
        it.inst = inst; it.op1 = a; it.op2 = b; it.waddr = wa; it.we = we;
        it.pc = {32'd0, $urandom};
        return it;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mid = '0; m_mid_v = 0; m_out_v = 0; m_ptr = 0;
        m_out_wd = '0; m_out_wa = '0; m_out_we = 0; m_out_id = 0;
    endtask

    task automatic drive();
        item_t a, b;
        a = (q0.size() != 0) ? q0[0] : '0;
        b = (q1.size() != 0) ? q1[0] : '0;
        bus.req0_valid = (q0.size() != 0);
        bus.req0_inst = a.inst; bus.req0_pc = a.pc; bus.req0_op1 = a.op1;
        bus.req0_op2 = a.op2; bus.req0_we = a.we; bus.req0_waddr = a.waddr;
        bus.req1_valid = (q1.size() != 0);
        bus.req1_inst = b.inst; bus.req1_pc = b.pc; bus.req1_op1 = b.op1;
        bus.req1_op2 = b.op2; bus.req1_we = b.we; bus.req1_waddr = b.waddr;
    endtask

    // One clock: drive, compare every output against the model, then advance the model.
    task automatic step();
        bit v0, v1, free, gid, e0, e1, move;
        item_t it;
        @(negedge clk);
        rst = rst_v;
        bus.rsp_ready = rdy_v;
        drive();
        #1;
        if (rst_v) model_reset();
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        free = !m_mid_v || !m_out_v || rdy_v;
        gid = (v0 && v1) ? m_ptr : v1;
        e0 = !rst_v && free && (v0 || v1) && !gid;
        e1 = !rst_v && free && (v0 || v1) && gid;
        chk("req0_ready", bus.req0_ready, e0);
        chk("req1_ready", bus.req1_ready, e1);
        chk("rsp_valid", bus.rsp_valid, m_out_v);
        chk("rsp_wdata", bus.rsp_wdata, m_out_wd);
        chk("rsp_waddr", bus.rsp_waddr, m_out_wa);
        chk("rsp_we", bus.rsp_we, m_out_we);
        chk("rsp_id", bus.rsp_id, m_out_id);
        chk("alu_inst", bus.alu_inst, m_mid.inst);
        chk("alu_pc", bus.alu_inst_addr, m_mid.pc);
        chk("alu_op1", bus.alu_op1, m_mid.op1);
        chk("alu_op2", bus.alu_op2, m_mid.op2);
        chk("alu_we", bus.alu_we, m_mid.we);
        chk("alu_waddr", bus.alu_waddr, m_mid.waddr);
        if (bus.rsp_valid && rdy_v) begin
            rsp_id_log.push_back(bus.rsp_id);
            rsp_wd_log.push_back(bus.rsp_wdata);
        end
        @(posedge clk);
        if (!rst_v) begin
            move = m_mid_v && (!m_out_v || rdy_v);
            if (move) begin
                m_out_v = 1; m_out_wd = ref_alu(m_mid); m_out_wa = m_mid.waddr;
                m_out_we = m_mid.we; m_out_id = m_mid.id;
            end else if (m_out_v && rdy_v) m_out_v = 0;
            if (e0 || e1) begin
                it = gid ? q1.pop_front() : q0.pop_front();
                it.id = gid;
                m_mid = it; m_mid_v = 1; m_ptr = !gid;
                acc_log.push_back(gid);
            end else if (move) m_mid_v = 0;
        end
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete(); rsp_id_log.delete(); rsp_wd_log.delete();
    endtask

    task automatic do_reset();
        rst_v = 1; rdy_v = 1;
        q0.delete(); q1.delete();
        step(); step();
        rst_v = 0;
        clear_logs();
    endtask

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] RTYP = 32'h0000_0033;

    initial begin
        bus.rsp_ready = 1'b1;
        drive();
        model_reset();

        // Reset values
        do_reset();
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_wdata", bus.rsp_wdata, 0);

        // Single ADDI from req0
        q0.push_back(mk(ADDI, 5, 7, 3, 1));
        step();
        chk("addi_no_rsp_yet", bus.rsp_valid, 0);
        step();
        chk("addi_rsp_valid", bus.rsp_valid, 1);
        chk("addi_wdata", bus.rsp_wdata, 12);
        chk("addi_waddr", bus.rsp_waddr, 3);
        chk("addi_we", bus.rsp_we, 1);
        chk("addi_id", bus.rsp_id, 0);
        step();

        // Both requesters contending: strict alternation, no bubbles
        do_reset();
        q0.push_back(mk(ADDI, 1, 2, 1, 1));
        q0.push_back(mk(ADDI, 3, 4, 2, 1));
        q1.push_back(mk(ADDI, 10, 20, 4, 1));
        q1.push_back(mk(ADDI, 30, 40, 5, 1));
        repeat (6) step();
        chk("alt_rsp_count", rsp_id_log.size(), 4);
        if (rsp_id_log.size() == 4) begin
            chk("alt_id0", rsp_id_log[0], 0); chk("alt_wd0", rsp_wd_log[0], 3);
            chk("alt_id1", rsp_id_log[1], 1); chk("alt_wd1", rsp_wd_log[1], 30);
            chk("alt_id2", rsp_id_log[2], 0); chk("alt_wd2", rsp_wd_log[2], 7);
            chk("alt_id3", rsp_id_log[3], 1); chk("alt_wd3", rsp_wd_log[3], 70);
        end

        // Backpressure: capacity of two, then in-order drain
        do_reset();
        rdy_v = 0;
        for (int i = 0; i < 3; i++) q1.push_back(mk(ADDI, 64'(100 + i), 1, 5'(8 + i), 1));
        repeat (5) step();
        chk("bp_accepts", acc_log.size(), 2);
        chk("bp_pending", q1.size(), 1);
        chk("bp_ready1", bus.req1_ready, 0);
        rdy_v = 1;
        repeat (6) step();
        chk("bp_drain_count", rsp_wd_log.size(), 3);
        if (rsp_wd_log.size() == 3) begin
            chk("bp_wd0", rsp_wd_log[0], 101);
            chk("bp_wd1", rsp_wd_log[1], 102);
            chk("bp_wd2", rsp_wd_log[2], 103);
            chk("bp_id2", rsp_id_log[2], 1);
        end

        // Non-ADDI opcode passes through, result zero
        do_reset();
        q0.push_back(mk(RTYP, 9, 4, 7, 1));
        step(); step();
        chk("rtyp_valid", bus.rsp_valid, 1);
        chk("rtyp_wdata", bus.rsp_wdata, 0);
        chk("rtyp_waddr", bus.rsp_waddr, 7);
        chk("rtyp_we", bus.rsp_we, 1);
        chk("rtyp_id", bus.rsp_id, 0);
        step();

        // Reset while a request is in flight
        do_reset();
        q0.push_back(mk(ADDI, 1, 1, 9, 1));
        step();
        rst_v = 1; step(); rst_v = 0;
        q0.delete();
        chk("rst_drop_valid", bus.rsp_valid, 0);
        clear_logs();
        repeat (3) step();
        chk("rst_drop_never_seen", rsp_id_log.size(), 0);
        q0.push_back(mk(ADDI, 2, 2, 1, 1));
        q1.push_back(mk(ADDI, 3, 3, 2, 1));
        repeat (5) step();
        chk("rst_ptr_first", acc_log.size() != 0 ? acc_log[0] : 1'b1, 0);
        chk("rst_post_count", rsp_wd_log.size(), 2);

        // req1 alone, then both: req0 next
        do_reset();
        q1.push_back(mk(ADDI, 1, 0, 1, 1));
        step();
        q0.push_back(mk(ADDI, 2, 0, 2, 1));
        q1.push_back(mk(ADDI, 3, 0, 3, 1));
        repeat (4) step();
        chk("ptr_acc_count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("ptr_acc0", acc_log[0], 1);
            chk("ptr_acc1", acc_log[1], 0);
            chk("ptr_acc2", acc_log[2], 1);
        end

        // Randomized traffic with backpressure and occasional reset
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (q0.size() < 3 && $urandom_range(0, 2) != 0)
                q0.push_back(mk(($urandom_range(0, 3) != 0) ? ADDI : RTYP,
                                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom)));
            if (q1.size() < 3 && $urandom_range(0, 2) != 0)
                q1.push_back(mk(($urandom_range(0, 3) != 0) ? ADDI : RTYP,
                                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom)));
            rdy_v = ($urandom_range(0, 3) != 0);
            rst_v = ($urandom_range(0, 149) == 0);
            step();
        end
        rst_v = 0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
